// File: rtl/ibex_md_issue_ctrl.sv
// Issue/response wrapper for the iterative multiply/divide unit. It latches one request,
// drives the unit until it reports valid, and keeps a one-entry cache of the last DIV/REM result.
module ibex_md_issue_ctrl #(
    parameter int unsigned TAG_W    = 5,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_operator_i,
    input  logic [1:0]       req_signed_mode_i,
    input  logic [31:0]      req_op_a_i,
    input  logic [31:0]      req_op_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             md_mult_en_o,
    output logic             md_div_en_o,
    output logic [1:0]       md_operator_o,
    output logic [1:0]       md_signed_mode_o,
    output logic [31:0]      md_op_a_o,
    output logic [31:0]      md_op_b_o,
    input  logic [31:0]      md_result_i,
    input  logic             md_valid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

    state_e            state_q;
    md_req_t           req_q, req_in, cache_key_q;
    logic [TAG_W-1:0]  tag_q;
    logic [31:0]       rsp_result_q, cache_res_q;
    logic              rsp_valid_q, mult_en_q, div_en_q;
    logic              discard_q, cache_vld_q;
    logic              cache_hit;

    assign req_in    = {req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i};
    // op[1] set means DIV or REM, the only cacheable operators
    assign cache_hit = CACHE_EN && cache_vld_q && req_operator_i[1] && (req_in == cache_key_q);

    assign req_ready_o      = (state_q == IDLE) & ~flush_i;
    assign busy_o           = (state_q != IDLE);
    assign md_mult_en_o     = mult_en_q;
    assign md_div_en_o      = div_en_q;
    assign md_operator_o    = req_q.op;
    assign md_signed_mode_o = req_q.mode;
    assign md_op_a_o        = req_q.a;
    assign md_op_b_o        = req_q.b;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_result_o     = rsp_result_q;
    assign rsp_tag_o        = tag_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            req_q        <= '0;
            tag_q        <= '0;
            rsp_result_q <= '0;
            rsp_valid_q  <= 1'b0;
            mult_en_q    <= 1'b0;
            div_en_q     <= 1'b0;
            discard_q    <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_key_q  <= '0;
            cache_res_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_q <= req_in;
                        tag_q <= req_tag_i;
                        if (cache_hit) begin
                            rsp_result_q <= cache_res_q;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            mult_en_q <= ~req_operator_i[1];
                            div_en_q  <= req_operator_i[1];
                            state_q   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (md_valid_i) begin
                        mult_en_q <= 1'b0;
                        div_en_q  <= 1'b0;
                        if (discard_q || flush_i) begin
                            discard_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            rsp_result_q <= md_result_i;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= RESP;
                            if (req_q.op[1]) begin
                                cache_key_q <= req_q;
                                cache_res_q <= md_result_i;
                                cache_vld_q <= 1'b1;
                            end
                        end
                    end else if (flush_i) begin
                        // The unit cannot be aborted, so keep it running and drop its result later
                        discard_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (flush_i || rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_md_issue_ctrl.sv
// Directed bench for ibex_md_issue_ctrl; the bench itself plays the mult/div unit.
module tb_ibex_md_issue_ctrl;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       req_operator_i;
    logic [1:0]       req_signed_mode_i;
    logic [31:0]      req_op_a_i;
    logic [31:0]      req_op_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    logic             md_mult_en_o;
    logic             md_div_en_o;
    logic [1:0]       md_operator_o;
    logic [1:0]       md_signed_mode_o;
    logic [31:0]      md_op_a_o;
    logic [31:0]      md_op_b_o;
    logic [31:0]      md_result_i;
    logic             md_valid_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    ibex_md_issue_ctrl #(.TAG_W(TAG_W), .CACHE_EN(1'b1)) dut (
        .clk               (clk),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_operator_i    (req_operator_i),
        .req_signed_mode_i (req_signed_mode_i),
        .req_op_a_i        (req_op_a_i),
        .req_op_b_i        (req_op_b_i),
        .req_tag_i         (req_tag_i),
        .flush_i           (flush_i),
        .md_mult_en_o      (md_mult_en_o),
        .md_div_en_o       (md_div_en_o),
        .md_operator_o     (md_operator_o),
        .md_signed_mode_o  (md_signed_mode_o),
        .md_op_a_o         (md_op_a_o),
        .md_op_b_o         (md_op_b_o),
        .md_result_i       (md_result_i),
        .md_valid_i        (md_valid_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_result_o      (rsp_result_o),
        .rsp_tag_o         (rsp_tag_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] mode,
                         input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
        req_valid_i       = 1'b1;
        req_operator_i    = op;
        req_signed_mode_i = mode;
        req_op_a_i        = a;
        req_op_b_i        = b;
        req_tag_i         = tag;
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic unit_done(input logic [31:0] res);
        md_valid_i  = 1'b1;
        md_result_i = res;
        tick();
        md_valid_i  = 1'b0;
        md_result_i = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        n_checks++; if ({md_mult_en_o, md_div_en_o} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b want 00", {md_mult_en_o, md_div_en_o}); end
        n_checks++; if ({md_op_a_o, md_op_b_o, rsp_result_o, rsp_tag_o} !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", md_op_a_o, md_op_b_o, rsp_result_o, rsp_tag_o); end
        rst_ni = 1'b1;
        tick();
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    endtask

    task automatic test_mull();
        logic div_seen = 1'b0;
        issue(2'd0, 2'b00, 32'd3, 32'd5, 5'd7);
        n_checks++; if (md_mult_en_o !== 1'b1) begin n_fail++; $display("FAIL mull_mult_en: got %b want 1", md_mult_en_o); end
        n_checks++; if ({md_op_a_o, md_op_b_o} !== {32'd3, 32'd5}) begin n_fail++; $display("FAIL mull_operands: got %h %h want 3 5", md_op_a_o, md_op_b_o); end
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL mull_ready_run: got %b want 0", req_ready_o); end
        for (int i = 0; i < 3; i++) begin
            div_seen = div_seen | md_div_en_o;
            n_checks++; if (md_mult_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL mull_run_hold: got en=%b rsp=%b want 1 0", md_mult_en_o, rsp_valid_o); end
            tick();
        end
        unit_done(32'd15);
        div_seen = div_seen | md_div_en_o;
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd15 || rsp_tag_o !== 5'd7) begin n_fail++; $display("FAIL mull_rsp: got v=%b r=%h t=%h want 1 f 7", rsp_valid_o, rsp_result_o, rsp_tag_o); end
        n_checks++; if (md_mult_en_o !== 1'b0) begin n_fail++; $display("FAIL mull_en_drop: got %b want 0", md_mult_en_o); end
        n_checks++; if (div_seen !== 1'b0) begin n_fail++; $display("FAIL mull_no_div_en: got %b want 0", div_seen); end
        tick();
        n_checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL mull_handshake: got v=%b busy=%b want 0 0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_div_cache();
        issue(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd3);
        n_checks++; if (md_div_en_o !== 1'b1 || md_mult_en_o !== 1'b0) begin n_fail++; $display("FAIL div_en: got d=%b m=%b want 1 0", md_div_en_o, md_mult_en_o); end
        tick();
        unit_done(32'hFFFF_FFFD);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_rsp: got v=%b r=%h want 1 fffffffd", rsp_valid_o, rsp_result_o); end
        tick();
        issue(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd4);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFD || rsp_tag_o !== 5'd4) begin n_fail++; $display("FAIL div_hit_rsp: got v=%b r=%h t=%h want 1 fffffffd 4", rsp_valid_o, rsp_result_o, rsp_tag_o); end
        n_checks++; if (md_div_en_o !== 1'b0) begin n_fail++; $display("FAIL div_hit_no_en: got %b want 0", md_div_en_o); end
        tick();
    endtask

    task automatic test_rem_replace();
        issue(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5);
        n_checks++; if (md_div_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rem_miss: got en=%b v=%b want 1 0", md_div_en_o, rsp_valid_o); end
        tick();
        unit_done(32'hFFFF_FFFF);
        n_checks++; if (rsp_result_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_rsp: got %h want ffffffff", rsp_result_o); end
        tick();
        issue(2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd6);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFF || md_div_en_o !== 1'b0) begin n_fail++; $display("FAIL rem_hit: got v=%b r=%h en=%b want 1 ffffffff 0", rsp_valid_o, rsp_result_o, md_div_en_o); end
        tick();
        // DIV entry was replaced, so the DIV misses now
        issue(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd7);
        n_checks++; if (md_div_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL div_after_rem_miss: got en=%b v=%b want 1 0", md_div_en_o, rsp_valid_o); end
        unit_done(32'hFFFF_FFFD);
        tick();
    endtask

    task automatic test_flush_run();
        issue(2'd2, 2'b00, 32'd100, 32'd7, 5'd8);
        for (int i = 0; i < 4; i++) tick();
        flush_i = 1'b1;
        n_checks++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready_o); end
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (md_div_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_drain: got en=%b v=%b want 1 0", md_div_en_o, rsp_valid_o); end
            tick();
        end
        unit_done(32'd14);
        n_checks++; if (md_div_en_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got en=%b v=%b busy=%b want 0 0 0", md_div_en_o, rsp_valid_o, busy_o); end
        n_checks++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b want 1", req_ready_o); end
        issue(2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd9);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL flush_cache_kept: got v=%b r=%h want 1 fffffffd", rsp_valid_o, rsp_result_o); end
        tick();
        issue(2'd2, 2'b00, 32'd100, 32'd7, 5'd10);
        n_checks++; if (md_div_en_o !== 1'b1) begin n_fail++; $display("FAIL flush_no_write: got en=%b want 1", md_div_en_o); end
        unit_done(32'd14);
        n_checks++; if (rsp_result_o !== 32'd14 || rsp_tag_o !== 5'd10) begin n_fail++; $display("FAIL div100_rsp: got r=%h t=%h want e a", rsp_result_o, rsp_tag_o); end
        tick();
    endtask

    task automatic test_flush_resp();
        rsp_ready_i = 1'b0;
        issue(2'd0, 2'b00, 32'd6, 32'd7, 5'd11);
        unit_done(32'd42);
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        tick();
        flush_i = 1'b0;
        n_checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_resp: got v=%b busy=%b want 0 0", rsp_valid_o, busy_o); end
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        issue(2'd1, 2'b11, 32'd2, 32'd3, 5'd12);
        unit_done(32'h0000_1234);
        req_valid_i    = 1'b1;
        req_operator_i = 2'd0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'h1234 || rsp_tag_o !== 5'd12 || req_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_hold: got v=%b r=%h t=%h rdy=%b want 1 1234 c 0", rsp_valid_o, rsp_result_o, rsp_tag_o, req_ready_o); end
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        n_checks++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b busy=%b rdy=%b want 0 0 1", rsp_valid_o, busy_o, req_ready_o); end
    endtask

    task automatic test_reset_in_run();
        issue(2'd2, 2'b00, 32'd100, 32'd7, 5'd13);
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd14) begin n_fail++; $display("FAIL pre_reset_hit: got v=%b r=%h want 1 e", rsp_valid_o, rsp_result_o); end
        tick();
        issue(2'd0, 2'b00, 32'd9, 32'd9, 5'd14);
        tick();
        rst_ni = 1'b0;
        #1;
        n_checks++; if ({md_mult_en_o, md_div_en_o, busy_o, rsp_valid_o} !== 4'b0000 || {md_op_a_o, md_op_b_o, md_operator_o} !== '0) begin n_fail++; $display("FAIL reset_in_run: got m=%b d=%b busy=%b v=%b a=%h want all 0", md_mult_en_o, md_div_en_o, busy_o, rsp_valid_o, md_op_a_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        issue(2'd2, 2'b00, 32'd100, 32'd7, 5'd15);
        n_checks++; if (md_div_en_o !== 1'b1 || rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_miss: got en=%b v=%b want 1 0", md_div_en_o, rsp_valid_o); end
        unit_done(32'd14);
        tick();
    endtask

    initial begin
        rst_ni            = 1'b0;
        req_valid_i       = 1'b0;
        req_operator_i    = '0;
        req_signed_mode_i = '0;
        req_op_a_i        = '0;
        req_op_b_i        = '0;
        req_tag_i         = '0;
        flush_i           = 1'b0;
        md_result_i       = '0;
        md_valid_i        = 1'b0;
        rsp_ready_i       = 1'b1;
        test_reset();
        test_mull();
        test_div_cache();
        test_rem_replace();
        test_flush_run();
        test_flush_resp();
        test_backpressure();
        test_reset_in_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
